// File: rtl/givens_rotator3.sv
// givens_rotator3: one Givens rotation about X, Y or Z (optionally transposed)
// applied to a 3-element signed fixed-point vector, using one shared multiplier.
// Build option: define GIVENS_SAT_EN to clamp rotated components instead of wrapping.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   in_valid / in_ready     input handshake (ready only while idle)
//   axis, inv               rotation axis (0=X,1=Y,2=Z,3=illegal), transpose select
//   cos_in, sin_in          rotation coefficients, Q(W-FRAC).FRAC
//   x_in, y_in, z_in        input vector
//   out_valid / out_ready   output handshake; outputs held while stalled
//   x_out, y_out, z_out     rotated vector
//   sat_flag, axis_err      result status, registered with the result
module givens_rotator3 #(
  parameter int W    = 16,
  parameter int FRAC = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   axis,
  input  logic         inv,
  input  logic [W-1:0] cos_in,
  input  logic [W-1:0] sin_in,
  input  logic [W-1:0] x_in,
  input  logic [W-1:0] y_in,
  input  logic [W-1:0] z_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] x_out,
  output logic [W-1:0] y_out,
  output logic [W-1:0] z_out,
  output logic         sat_flag,
  output logic         axis_err
);

  localparam int PW = 2 * W + 1;  // product width
  localparam int AW = 2 * W + 2;  // accumulator width

  localparam logic signed [AW-1:0] HALF = AW'(1) << (FRAC - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    M0   = 3'd1,
    M1   = 3'd2,
    M2   = 3'd3,
    M3   = 3'd4,
    OUT  = 3'd5
  } state_t;

  state_t state, next_state;

  // Captured operands
  logic        [W-1:0] c_r;
  logic signed [W:0]   s_r;
  logic signed [W-1:0] x_r, y_r, z_r;
  logic        [1:0]   axis_r;

  logic signed [AW-1:0] acc;
  logic        [W-1:0]  a_res;
  logic                 sat_a;

  // Effective sine is one bit wider so negating the most negative sin is exact
  logic signed [W:0] sin_ext, s_eff;
  assign sin_ext = {sin_in[W-1], sin_in};
  assign s_eff   = inv ? -sin_ext : sin_ext;

  // Rotated pair selection: X -> (y,z), Y -> (x,z), Z -> (x,y)
  logic signed [W-1:0] op_a, op_b;
  assign op_a = (axis_r == 2'd0) ? y_r : x_r;
  assign op_b = (axis_r == 2'd2) ? y_r : z_r;

  // Shared multiplier: M0 c*a, M1 s*b, M2 s*a, M3 c*b
  logic signed [W:0]    mul_k;
  logic signed [W-1:0]  mul_v;
  logic signed [PW-1:0] prod;
  logic signed [AW-1:0] prod_ext;

  assign mul_k    = (state == M0 || state == M3) ? {c_r[W-1], c_r} : s_r;
  assign mul_v    = (state == M0 || state == M2) ? op_a : op_b;
  assign prod     = PW'(mul_k) * PW'(mul_v);
  assign prod_ext = AW'(prod);

  logic signed [AW-1:0] acc_sum;
  always_comb begin
    acc_sum = prod_ext;
    if (state == M1)      acc_sum = acc - prod_ext;
    else if (state == M3) acc_sum = acc + prod_ext;
  end

  // Round half-up then arithmetic shift down to integer scale
  logic signed [AW-1:0] rnd, shifted;
  assign rnd     = acc_sum + HALF;
  assign shifted = rnd >>> FRAC;

  logic [W-1:0] red_val;
  logic         red_sat;

`ifdef GIVENS_SAT_EN
  localparam logic signed [AW-1:0] MAXV = (AW'(1) << (W - 1)) - AW'(1);
  localparam logic signed [AW-1:0] MINV = -(AW'(1) << (W - 1));

  always_comb begin
    red_val = shifted[W-1:0];
    red_sat = 1'b0;
    if (shifted > MAXV) begin
      red_val = MAXV[W-1:0];
      red_sat = 1'b1;
    end else if (shifted < MINV) begin
      red_val = MINV[W-1:0];
      red_sat = 1'b1;
    end
  end
`else
  // Wrap: keep the low W bits; upper bits intentionally dropped
  logic unused_hi;
  assign unused_hi = ^shifted[AW-1:W];

  always_comb begin
    red_val = shifted[W-1:0];
    red_sat = 1'b0;
  end
`endif

  assign in_ready = (state == IDLE);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (in_valid) next_state = M0;
      M0:      next_state = M1;
      M1:      next_state = M2;
      M2:      next_state = M3;
      M3:      next_state = OUT;
      OUT:     if (out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_r       <= '0;
      s_r       <= '0;
      x_r       <= '0;
      y_r       <= '0;
      z_r       <= '0;
      axis_r    <= '0;
      acc       <= '0;
      a_res     <= '0;
      sat_a     <= 1'b0;
      out_valid <= 1'b0;
      x_out     <= '0;
      y_out     <= '0;
      z_out     <= '0;
      sat_flag  <= 1'b0;
      axis_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            c_r    <= cos_in;
            s_r    <= s_eff;
            x_r    <= x_in;
            y_r    <= y_in;
            z_r    <= z_in;
            axis_r <= axis;
          end
        end
        M0, M2: acc <= acc_sum;
        M1: begin
          acc   <= acc_sum;
          a_res <= red_val;
          sat_a <= red_sat;
        end
        M3: begin
          acc       <= acc_sum;
          out_valid <= 1'b1;
          axis_err  <= (axis_r == 2'd3);
          sat_flag  <= (axis_r != 2'd3) && (sat_a || red_sat);
          case (axis_r)
            2'd0: begin x_out <= x_r;   y_out <= a_res;   z_out <= red_val; end
            2'd1: begin x_out <= a_res; y_out <= y_r;     z_out <= red_val; end
            2'd2: begin x_out <= a_res; y_out <= red_val; z_out <= z_r;     end
            default: begin x_out <= x_r; y_out <= y_r;    z_out <= z_r;     end
          endcase
        end
        OUT: if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_givens_rotator3.sv
// Self-checking bench for givens_rotator3: directed cases plus random transactions
// compared against an integer-arithmetic rotation model.
module tb_givens_rotator3;
  localparam int W = 16;
  localparam int FRAC = 12;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [1:0]   axis = 2'd0;
  logic         inv = 1'b0;
  logic [W-1:0] cos_in = '0, sin_in = '0, x_in = '0, y_in = '0, z_in = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] x_out, y_out, z_out;
  logic         sat_flag, axis_err;

  int checks = 0;
  int errors = 0;

  givens_rotator3 #(.W(W), .FRAC(FRAC)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .axis(axis), .inv(inv), .cos_in(cos_in), .sin_in(sin_in),
    .x_in(x_in), .y_in(y_in), .z_in(z_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .x_out(x_out), .y_out(y_out), .z_out(z_out),
    .sat_flag(sat_flag), .axis_err(axis_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Round half-up to integer scale, then clamp or wrap to 16 bits
  function automatic logic [15:0] reduce(input longint v, output bit sat);
    longint r;
    r = (v + 2048) >>> 12;
    sat = 1'b0;
`ifdef GIVENS_SAT_EN
    if (r > 32767) begin sat = 1'b1; return 16'h7FFF; end
    if (r < -32768) begin sat = 1'b1; return 16'h8000; end
`endif
    return r[15:0];
  endfunction

  // Rotation model: a' = c*a - s*b, b' = s*a + c*b with s negated for inverse
  task automatic model(input logic [1:0] ax, input logic iv,
                       input logic [15:0] c, s, x, y, z,
                       output logic [15:0] ex, ey, ez, output logic esat, output logic eerr);
    longint cv, sv, xv, yv, zv, a, b;
    logic [15:0] ap, bp;
    bit sa, sb;
    cv = longint'($signed(c));
    sv = longint'($signed(s));
    if (iv) sv = -sv;
    xv = longint'($signed(x));
    yv = longint'($signed(y));
    zv = longint'($signed(z));
    ex = x; ey = y; ez = z; esat = 1'b0; eerr = 1'b0;
    if (ax == 2'd3) begin
      eerr = 1'b1;
    end else begin
      a = (ax == 2'd0) ? yv : xv;
      b = (ax == 2'd2) ? yv : zv;
      ap = reduce(cv * a - sv * b, sa);
      bp = reduce(sv * a + cv * b, sb);
      esat = sa | sb;
      case (ax)
        2'd0: begin ey = ap; ez = bp; end
        2'd1: begin ex = ap; ez = bp; end
        default: begin ex = ap; ey = bp; end
      endcase
    end
  endtask

  // Present one transaction and consume the accept edge
  task automatic start(input logic [1:0] ax, input logic iv,
                       input logic [15:0] c, s, x, y, z);
    int n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check("in_ready_wait", 32'(in_ready), 32'd1);
    axis = ax; inv = iv; cos_in = c; sin_in = s; x_in = x; y_in = y; z_in = z;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("busy_in_ready", 32'(in_ready), 32'd0);
  endtask

  task automatic wait_out();
    int lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    check("latency", 32'(lat), 32'd4);
  endtask

  task automatic check_result(input string tag, input logic [1:0] ax, input logic iv,
                              input logic [15:0] c, s, x, y, z);
    logic [15:0] ex, ey, ez;
    logic esat, eerr;
    model(ax, iv, c, s, x, y, z, ex, ey, ez, esat, eerr);
    check({tag, "_x"}, 32'(x_out), 32'(ex));
    check({tag, "_y"}, 32'(y_out), 32'(ey));
    check({tag, "_z"}, 32'(z_out), 32'(ez));
    check({tag, "_sat"}, 32'(sat_flag), 32'(esat));
    check({tag, "_err"}, 32'(axis_err), 32'(eerr));
  endtask

  task automatic txn(input string tag, input logic [1:0] ax, input logic iv,
                     input logic [15:0] c, s, x, y, z);
    start(ax, iv, c, s, x, y, z);
    wait_out();
    check_result(tag, ax, iv, c, s, x, y, z);
    @(posedge clk); #1;
    check({tag, "_drop"}, 32'(out_valid), 32'd0);
    check({tag, "_idle"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [1:0]  rax;
    logic        riv;
    logic [15:0] rc, rs, rx, ry, rz;

    // Reset state
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_x", 32'(x_out), 32'd0);
    check("rst_y", 32'(y_out), 32'd0);
    check("rst_z", 32'(z_out), 32'd0);
    check("rst_sat", 32'(sat_flag), 32'd0);
    check("rst_err", 32'(axis_err), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases
    txn("ident", 2'd1, 1'b0, 16'h1000, 16'h0000, 16'h1234, 16'hF000, 16'h0400);
    check("ident_const_x", 32'(x_out), 32'h1234);
    txn("z90", 2'd2, 1'b0, 16'h0000, 16'h1000, 16'h1000, 16'h0800, 16'h0400);
    check("z90_const_x", 32'(x_out), 32'hF800);
    txn("z90inv", 2'd2, 1'b1, 16'h0000, 16'h1000, 16'h1000, 16'h0800, 16'h0400);
    check("z90inv_const_y", 32'(y_out), 32'hF000);
    txn("y90", 2'd1, 1'b0, 16'h0000, 16'h1000, 16'h1000, 16'h0200, 16'h0400);
    check("y90_const_x", 32'(x_out), 32'hFC00);
    txn("x90", 2'd0, 1'b0, 16'h0000, 16'h1000, 16'h1000, 16'h0200, 16'h0400);
    check("x90_const_y", 32'(y_out), 32'hFC00);
    txn("rnd_pos", 2'd2, 1'b0, 16'h0800, 16'h0000, 16'h0001, 16'h0000, 16'h0000);
    check("rnd_pos_const", 32'(x_out), 32'h0001);
    txn("rnd_neg", 2'd2, 1'b0, 16'h0800, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000);
    check("rnd_neg_const", 32'(x_out), 32'h0000);
    txn("sat", 2'd2, 1'b0, 16'h1000, 16'h1000, 16'h7000, 16'h7000, 16'h0000);
`ifdef GIVENS_SAT_EN
    check("sat_const_y", 32'(y_out), 32'h7FFF);
`else
    check("sat_const_y", 32'(y_out), 32'hE000);
`endif
    txn("neg_min_sin", 2'd2, 1'b1, 16'h0000, 16'h8000, 16'h1000, 16'h0000, 16'h0000);
    txn("illegal", 2'd3, 1'b0, 16'h0123, 16'h0456, 16'hABCD, 16'h1357, 16'h2468);
    check("illegal_const_x", 32'(x_out), 32'hABCD);

    // Backpressure: result held for 10 cycles, busy-time in_valid ignored
    out_ready = 1'b0;
    start(2'd0, 1'b1, 16'h0B50, 16'h0B50, 16'h0321, 16'hF123, 16'h0777);
    wait_out();
    for (int i = 0; i < 10; i++) begin
      axis = 2'($urandom_range(0, 3));
      cos_in = 16'($urandom); sin_in = 16'($urandom);
      x_in = 16'($urandom); y_in = 16'($urandom); z_in = 16'($urandom);
      in_valid = (i % 2 == 0);
      @(posedge clk); #1;
      check_result("stall", 2'd0, 1'b1, 16'h0B50, 16'h0B50, 16'h0321, 16'hF123, 16'h0777);
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("release_valid", 32'(out_valid), 32'd0);
    check("release_in_ready", 32'(in_ready), 32'd1);
    txn("after_stall", 2'd1, 1'b0, 16'h0800, 16'h0DDB, 16'h0400, 16'h0500, 16'hFA00);

    // Reset during M2
    start(2'd2, 1'b0, 16'h1000, 16'h0800, 16'h2000, 16'h1000, 16'h0100);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_x", 32'(x_out), 32'd0);
    check("midrst_y", 32'(y_out), 32'd0);
    check("midrst_z", 32'(z_out), 32'd0);
    check("midrst_err", 32'(axis_err), 32'd0);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Random transactions
    for (int i = 0; i < 40; i++) begin
      rax = 2'($urandom_range(0, 3));
      riv = 1'($urandom_range(0, 1));
      rc = 16'($urandom); rs = 16'($urandom);
      rx = 16'($urandom); ry = 16'($urandom); rz = 16'($urandom);
      if (i % 2 == 0) begin
        rc = 16'($signed(rc) >>> 2); rs = 16'($signed(rs) >>> 2);
      end
      txn("rand", rax, riv, rc, rs, rx, ry, rz);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
